// File: rtl/dsc_op_sequencer_if.sv
// Request / result handshake and stream monitor bundle for dsc_op_sequencer.
// The master side is the binary requester; the slave side is the sequencer.
interface dsc_op_sequencer_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     mode;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           abort;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] result;
  logic           sn_a;
  logic           sn_b;
  logic           sn_y;

  modport master (
    output in_valid, mode, a, b, abort, out_ready,
    input  in_ready, busy, out_valid, result, sn_a, sn_b, sn_y
  );

  modport slave (
    input  in_valid, mode, a, b, abort, out_ready,
    output in_ready, busy, out_valid, result, sn_a, sn_b, sn_y
  );
endinterface

// File: rtl/dsc_op_sequencer.sv
// Deterministic stochastic computing sequencer: latches two N-bit operands,
// drives a free counter and a clock-divided counter through per-operand
// comparators, combines the unary streams (AND = multiply/min, OR = max)
// and counts the result stream back into an exact 2N-bit binary value.
module dsc_op_sequencer #(
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst,
  dsc_op_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N-1:0]   CTR_MAX     = {N{1'b1}};
  localparam logic [2*N-1:0] CYC_MUL_END = {(2*N){1'b1}};
  localparam logic [2*N-1:0] CYC_MM_END  = {{N{1'b0}}, {N{1'b1}}};

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [1:0]     mode_q, mode_d;
  logic [N-1:0]   ctr_a_q, ctr_a_d;
  logic [N-1:0]   ctr_b_q, ctr_b_d;
  logic [2*N-1:0] cyc_q, cyc_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
  logic           out_valid_q, out_valid_d;

  logic           running;
  logic           is_mul;
  logic           is_max;
  logic           last_cyc;
  logic [N-1:0]   b_cmp;
  logic           sn_a;
  logic           sn_b;
  logic           sn_y;

  // Stream generation: comparators against the counters, forced low outside RUN.
  // Multiply pairs A with the fast counter and B with the divided counter so every
  // (ctr_a, ctr_b) pair is visited once; min/max compare both against the fast one.
  always_comb begin
    running  = (state_q == RUN);
    is_mul   = (mode_q == 2'b00) || (mode_q == 2'b11);
    is_max   = (mode_q == 2'b10);
    b_cmp    = is_mul ? ctr_b_q : ctr_a_q;
    sn_a     = running && (a_q > ctr_a_q);
    sn_b     = running && (b_q > b_cmp);
    sn_y     = is_max ? (sn_a | sn_b) : (sn_a & sn_b);
    last_cyc = is_mul ? (cyc_q == CYC_MUL_END) : (cyc_q == CYC_MM_END);
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    ctr_a_d = ctr_a_q;
    ctr_b_d = ctr_b_q;
    cyc_d   = cyc_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          ctr_a_d = '0;
          ctr_b_d = '0;
          cyc_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          ctr_a_d = '0;
          ctr_b_d = '0;
          cyc_d   = '0;
          acc_d   = '0;
        end else begin
          acc_d   = acc_q + {{(2*N-1){1'b0}}, sn_y};
          ctr_a_d = ctr_a_q + 1'b1;
          if (ctr_a_q == CTR_MAX) begin
            ctr_b_d = ctr_b_q + 1'b1;
          end
          cyc_d = cyc_q + 1'b1;
          if (last_cyc) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous reset to an idle, cleared block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= '0;
      ctr_a_q     <= '0;
      ctr_b_q     <= '0;
      cyc_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      ctr_a_q     <= ctr_a_d;
      ctr_b_q     <= ctr_b_d;
      cyc_q       <= cyc_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = acc_q;
  assign bus.sn_a      = sn_a;
  assign bus.sn_b      = sn_b;
  assign bus.sn_y      = sn_y;

endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Self-checking bench for dsc_op_sequencer: directed test-plan scenarios plus
// randomized operations checked against an arithmetic / stream-rule model.
module tb_dsc_op_sequencer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  int         lat_obs;
  logic [7:0] res_obs;
  logic [7:0] res0_obs;
  logic       idle_obs;
  logic       ov_after_obs;
  bit         sa_h[$];
  bit         sb_h[$];
  bit         sy_h[$];

  dsc_op_sequencer_if #(.N(N)) bus ();

  dsc_op_sequencer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Exact arithmetic result of an operation.
  function automatic int ref_result(input logic [1:0] m, input int x, input int y);
    if (m == 2'b01) return (x < y) ? x : y;
    if (m == 2'b10) return (x > y) ? x : y;
    return x * y;
  endfunction

  // Number of RUN cycles of an operation.
  function automatic int ref_len(input logic [1:0] m);
    return (m == 2'b01 || m == 2'b10) ? 16 : 256;
  endfunction

  // Cycle-by-cycle comparison of recorded streams with the stream rules;
  // returns the number of disagreeing cycles (plus one if the length is wrong).
  function automatic int stream_errs(input logic [1:0] m, input int x, input int y);
    int  bad;
    bit  ea, eb, ey;
    bit  mul;
    bad = (sa_h.size() != ref_len(m)) ? 1 : 0;
    mul = (m == 2'b00 || m == 2'b11);
    for (int k = 0; k < sa_h.size(); k++) begin
      ea = (x > (k % 16));
      eb = mul ? (y > (k / 16)) : (y > (k % 16));
      ey = (m == 2'b10) ? (ea | eb) : (ea & eb);
      if (sa_h[k] != ea || sb_h[k] != eb || sy_h[k] != ey) bad++;
    end
    return bad;
  endfunction

  // Issue one request at the current negedge, record the streams during RUN
  // (bounded), and capture latency / result. With rdy=1, also samples one cycle
  // after DONE. Ends on a negedge. Operands are scrambled during RUN.
  task automatic run_op(input logic [1:0] m, input logic [3:0] x, input logic [3:0] y,
                        input logic rdy);
    sa_h.delete();
    sb_h.delete();
    sy_h.delete();
    bus.in_valid  = 1'b1;
    bus.mode      = m;
    bus.a         = x;
    bus.b         = y;
    bus.out_ready = rdy;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mode     = 2'($urandom_range(0, 3));
    bus.a        = 4'($urandom_range(0, 15));
    bus.b        = 4'($urandom_range(0, 15));
    res0_obs = bus.result;
    lat_obs  = 0;
    while (!bus.out_valid && lat_obs < 400) begin
      sa_h.push_back(bus.sn_a);
      sb_h.push_back(bus.sn_b);
      sy_h.push_back(bus.sn_y);
      lat_obs++;
      @(negedge clk);
    end
    res_obs = bus.result;
    if (rdy) begin
      @(negedge clk);
      idle_obs     = bus.in_ready;
      ov_after_obs = bus.out_valid;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid, bus.sn_a, bus.sn_b, bus.sn_y} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b exp 100000",
               {bus.in_ready, bus.busy, bus.out_valid, bus.sn_a, bus.sn_b, bus.sn_y});
    end
    checks++;
    if (bus.result !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_result got %0d exp 0", bus.result);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got %b exp 100", {bus.in_ready, bus.busy, bus.out_valid});
    end
  endtask

  task automatic test_multiply();
    logic [3:0] xs[5] = '{4'd9, 4'd15, 4'd0, 4'd1, 4'd12};
    logic [3:0] ys[5] = '{4'd7, 4'd15, 4'd13, 4'd1, 4'd10};
    logic [1:0] ms[5] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
    int         exp;
    int         sa_ones;
    for (int i = 0; i < 5; i++) begin
      run_op(ms[i], xs[i], ys[i], 1'b1);
      exp = ref_result(ms[i], int'(xs[i]), int'(ys[i]));
      checks++;
      if (lat_obs != 256) begin
        errors++;
        $display("[TB] FAIL mul_latency got %0d exp 256 (a=%0d b=%0d)", lat_obs, xs[i], ys[i]);
      end
      checks++;
      if (res_obs !== 8'(exp)) begin
        errors++;
        $display("[TB] FAIL mul_result got %0d exp %0d (a=%0d b=%0d)", res_obs, exp, xs[i], ys[i]);
      end
      checks++;
      if (stream_errs(ms[i], int'(xs[i]), int'(ys[i])) != 0) begin
        errors++;
        $display("[TB] FAIL mul_streams got %0d bad cycles exp 0 (a=%0d b=%0d)",
                 stream_errs(ms[i], int'(xs[i]), int'(ys[i])), xs[i], ys[i]);
      end
      checks++;
      if ({idle_obs, ov_after_obs} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL mul_back_to_idle got %b exp 10", {idle_obs, ov_after_obs});
      end
      checks++;
      if (res0_obs !== 8'd0) begin
        errors++;
        $display("[TB] FAIL mul_result_clear got %0d exp 0", res0_obs);
      end
      if (xs[i] == 4'd0) begin
        sa_ones = 0;
        foreach (sa_h[k]) sa_ones += int'(sa_h[k]);
        checks++;
        if (sa_ones != 0) begin
          errors++;
          $display("[TB] FAIL mul_zero_sn_a got %0d ones exp 0", sa_ones);
        end
      end
    end
  endtask

  task automatic test_minmax();
    int bad;
    run_op(2'b01, 4'd5, 4'd11, 1'b1);
    checks++;
    if (lat_obs != 16 || res_obs !== 8'd5) begin
      errors++;
      $display("[TB] FAIL min_5_11 got res %0d lat %0d exp res 5 lat 16", res_obs, lat_obs);
    end
    checks++;
    if (stream_errs(2'b01, 5, 11) != 0) begin
      errors++;
      $display("[TB] FAIL min_streams got %0d bad cycles exp 0", stream_errs(2'b01, 5, 11));
    end
    run_op(2'b10, 4'd5, 4'd11, 1'b1);
    checks++;
    if (lat_obs != 16 || res_obs !== 8'd11) begin
      errors++;
      $display("[TB] FAIL max_5_11 got res %0d lat %0d exp res 11 lat 16", res_obs, lat_obs);
    end
    bad = (sy_h.size() != 16) ? 1 : 0;
    foreach (sy_h[k]) if (sy_h[k] != (k <= 10)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL max_sn_y_window got %0d bad cycles exp 0", bad);
    end
  endtask

  task automatic test_backpressure();
    run_op(2'b00, 4'd3, 4'd4, 1'b0);
    checks++;
    if (lat_obs != 256 || res_obs !== 8'd12) begin
      errors++;
      $display("[TB] FAIL bp_result got res %0d lat %0d exp res 12 lat 256", res_obs, lat_obs);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b0, 8'd12}) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d got ov=%b ir=%b res=%0d exp ov=1 ir=0 res=12",
                 i, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b0, 1'b1, 8'd12}) begin
      errors++;
      $display("[TB] FAIL bp_release got ov=%b ir=%b res=%0d exp ov=0 ir=1 res=12",
               bus.out_valid, bus.in_ready, bus.result);
    end
  endtask

  task automatic test_interrupt();
    int lat;
    int seen_ov;
    // New requests while running are refused and do not disturb the operation.
    bus.in_valid  = 1'b1;
    bus.mode      = 2'b00;
    bus.a         = 4'd6;
    bus.b         = 4'd5;
    bus.out_ready = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!bus.out_valid && lat < 400) begin
      if (lat == 10) begin
        checks++;
        if ({bus.in_ready, bus.busy} !== 2'b01) begin
          errors++;
          $display("[TB] FAIL run_refuses got ir/busy %b exp 01", {bus.in_ready, bus.busy});
        end
      end
      bus.a    = 4'($urandom_range(0, 15));
      bus.b    = 4'($urandom_range(0, 15));
      bus.mode = 2'($urandom_range(0, 3));
      lat++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++;
    if (lat != 256 || bus.result !== 8'd30) begin
      errors++;
      $display("[TB] FAIL run_ignore_inputs got res %0d lat %0d exp res 30 lat 256", bus.result, lat);
    end
    @(negedge clk);

    // Abort at cycle 100 of a multiply.
    bus.in_valid = 1'b1;
    bus.mode     = 2'b00;
    bus.a        = 4'd9;
    bus.b        = 4'd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (100) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid, bus.result} !== {3'b100, 8'd0}) begin
      errors++;
      $display("[TB] FAIL abort_mid got ir/busy/ov %b res %0d exp 100 res 0",
               {bus.in_ready, bus.busy, bus.out_valid}, bus.result);
    end
    seen_ov = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.out_valid) seen_ov++;
    end
    checks++;
    if (seen_ov != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_valid got %0d valid cycles exp 0", seen_ov);
    end
    run_op(2'b00, 4'd2, 4'd2, 1'b1);
    checks++;
    if (res_obs !== 8'd4 || lat_obs != 256) begin
      errors++;
      $display("[TB] FAIL after_abort got res %0d lat %0d exp res 4 lat 256", res_obs, lat_obs);
    end

    // Abort on the last RUN cycle wins over completion.
    bus.in_valid = 1'b1;
    bus.mode     = 2'b01;
    bus.a        = 4'd7;
    bus.b        = 4'd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL abort_last got ir/busy/ov %b exp 100", {bus.in_ready, bus.busy, bus.out_valid});
    end

    // Abort while DONE is ignored.
    run_op(2'b01, 4'd3, 4'd8, 1'b0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if ({bus.out_valid, bus.result} !== {1'b1, 8'd3}) begin
      errors++;
      $display("[TB] FAIL abort_done got ov %b res %0d exp ov 1 res 3", bus.out_valid, bus.result);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    bus.in_valid = 1'b1;
    bus.mode     = 2'b00;
    bus.a        = 4'd11;
    bus.b        = 4'd13;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (50) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy, bus.out_valid, bus.sn_a, bus.sn_b, bus.sn_y, bus.result}
        !== {6'b100000, 8'd0}) begin
      errors++;
      $display("[TB] FAIL async_reset got flags %b res %0d exp 100000 res 0",
               {bus.in_ready, bus.busy, bus.out_valid, bus.sn_a, bus.sn_b, bus.sn_y}, bus.result);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(2'b01, 4'd7, 4'd6, 1'b1);
    checks++;
    if (res_obs !== 8'd6 || lat_obs != 16) begin
      errors++;
      $display("[TB] FAIL after_reset_min got res %0d lat %0d exp res 6 lat 16", res_obs, lat_obs);
    end
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [3:0] x;
    logic [3:0] y;
    int         exp;
    for (int i = 0; i < 16; i++) begin
      m = 2'($urandom_range(0, 3));
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      run_op(m, x, y, 1'b1);
      exp = ref_result(m, int'(x), int'(y));
      checks++;
      if (res_obs !== 8'(exp) || lat_obs != ref_len(m)) begin
        errors++;
        $display("[TB] FAIL rand_op mode %0d a=%0d b=%0d got res %0d lat %0d exp res %0d lat %0d",
                 m, x, y, res_obs, lat_obs, exp, ref_len(m));
      end
      checks++;
      if (stream_errs(m, int'(x), int'(y)) != 0) begin
        errors++;
        $display("[TB] FAIL rand_streams mode %0d a=%0d b=%0d got %0d bad cycles exp 0",
                 m, x, y, stream_errs(m, int'(x), int'(y)));
      end
    end
  endtask

  // Scenario sequence; each operation starts from the IDLE negedge left by the previous one.
  initial begin
    test_reset();
    test_multiply();
    test_minmax();
    test_backpressure();
    test_interrupt();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsc_op_sequencer.md
# dsc_op_sequencer

Sequencer for one deterministic stochastic computing (DSC) operation on two N-bit unsigned operands. It holds the operands and runs the unary-stream generators: a free counter, a clock-divided counter and one comparator per operand. It combines the two streams bit by bit, counts the result stream back into binary, and returns the exact result through a valid/ready handshake. It sits between a binary requester and the shared DSC datapath, replacing hand-sequenced counter enables and resets.

## Interface
- N, 4, operand width; stream period is 2^N cycles.
- clk  in  1  clock, all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- mode  in  2  operation select: 00 multiply, 01 min, 10 max, 11 multiply.
- a  in  N  operand A, unsigned.
- b  in  N  operand B, unsigned.
- abort  in  1  synchronous cancel of a running operation.
- busy  out  1  high in RUN.
- out_valid  out  1  result available, high only in DONE.
- out_ready  in  1  consumer accepts the result.
- result  out  2N  binary count of ones in the result stream.
- sn_a, sn_b, sn_y  out  1 each  current stream bits, for monitoring; 0 outside RUN.

## Operation
- States:
  - IDLE: in_ready=1. Advances to RUN on in_valid at a clock edge; a, b and mode are latched into internal registers, and ctr_a, ctr_b, cyc and acc are cleared.
  - RUN: busy=1. Advances to DONE on the final cycle.
  - DONE: out_valid=1. Advances to IDLE on out_ready.
- Streams:
  - sn_a = (a_reg > ctr_a).
  - sn_b = (b_reg > ctr_b) in multiply mode; (b_reg > ctr_a) in min/max mode.
- Counters, all N-bit with natural wrap:
  - ctr_a increments every RUN cycle.
  - ctr_b increments only on RUN cycles where ctr_a == 2^N-1 (clock division).
- Combine:
  - sn_y = sn_a & sn_b for multiply and min.
  - sn_y = sn_a | sn_b for max.
- Accumulate: acc (2N bits) += sn_y every RUN cycle. result is driven from acc.
- Run length L (2N-bit cycle counter cyc):
  - multiply: L = 2^(2N).
  - min/max: L = 2^N.
  - cyc == L-1 marks the last RUN cycle.
- Exact results:
  - multiply: result = a*b.
  - min: result = min(a,b).
  - max: result = max(a,b).
  - Maximum value is (2^N-1)^2, which fits in 2N bits; no overflow is possible.
- abort in RUN: go to IDLE at the next edge. No out_valid is produced; acc is cleared. abort in IDLE or DONE is ignored.
- a, b and mode are ignored outside IDLE. Input changes during RUN have no effect.
- rst at any time: state IDLE, all counters and registers 0. Any operation in progress is lost.

## Timing
- Reset values: in_ready=1; busy=0; out_valid=0; result=0; sn_a=sn_b=sn_y=0.
- Accept edge E0 (IDLE, in_valid=1): busy=1 and in_ready=0 from E0.
- Stream cycle k (k = 0..L-1) lies between edges Ek and Ek+1. During it, ctr_a = k mod 2^N and ctr_b = k div 2^N.
- sn_* are combinational from the counters and a_reg/b_reg, valid throughout each RUN cycle.
- At edge EL:
  - the final sn_y is added into acc;
  - state goes to DONE, so out_valid=1 and busy=0 from EL;
  - result is stable and final from EL.
- Latency from accept edge to out_valid is L cycles: 256 for multiply and 16 for min/max at N=4.
- Handshake:
  - result is held constant while out_valid=1 and out_ready=0, for any number of cycles.
  - A DONE edge with out_ready=1 goes to IDLE; in_ready=1 from that edge.
  - A new request is accepted no earlier than the following edge, so the minimum gap between operations is one IDLE cycle.
- result holds its last value in IDLE until the next accept, when it clears to 0.
- abort and the last RUN cycle at the same edge: abort wins. The block goes to IDLE with no out_valid.

## Test plan
- Multiply, a=9, b=7, out_ready=1 → out_valid rises exactly 256 cycles after the accept edge; result=63; back in IDLE one cycle later.
- Multiply at the corners: a=15, b=15 → 225; a=0, b=13 → 0 with sn_a=0 throughout; a=1, b=1 → 1.
- Min and max, a=5, b=11 → min gives 5 and max gives 11, each after 16 cycles; sn_y in max mode is 1 for exactly cycles 0..10.
- Backpressure: multiply a=3, b=4 with out_ready held low for 20 cycles after out_valid → result stays 12 and in_ready stays 0. Raise out_ready → IDLE at the next edge.
- Interruptions: a request with in_valid during RUN is not accepted. abort at cycle 100 of a multiply → IDLE with no out_valid; the next request a=2, b=2 returns 4.
- Reset mid-run: assert rst asynchronously at cycle 50 → all outputs return to their reset values immediately. A subsequent min request a=7, b=6 returns 6.
